// File: rtl/vga_pkg.sv
// Shared timing constants, framebuffer geometry and FSM state type for the
// VGA scan-out block.
package vga_pkg;

    // Horizontal timing in pixel clocks.
    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing in lines.
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_TOTAL      = 10'd525;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
    localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Framebuffer geometry.
    localparam int unsigned FB_AW    = 15;
    localparam int unsigned COLOUR_W = 3;
    localparam logic [7:0]  FB_W     = 8'd160;
    localparam logic [6:0]  FB_H     = 7'd120;
    localparam logic [14:0] FB_DEPTH = 15'd19200;
    localparam logic [14:0] FB_LAST  = FB_DEPTH - 15'd1;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    // Linear framebuffer address y*160 + x, built from shifts and adds.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [FB_AW-1:0] yw;
        logic [FB_AW-1:0] xw;
        yw = {{(FB_AW-7){1'b0}}, y};
        xw = {{(FB_AW-8){1'b0}}, x};
        return (yw << 7) + (yw << 5) + xw;
    endfunction

endpackage

// File: rtl/vga_scanout_fb_ram.sv
// 160x120x3 framebuffer: one synchronous write port, one registered read
// port. A read of the address being written returns the previous contents.
module fb_ram
    import vga_pkg::*;
(
    input  logic                Clock,
    input  logic                we,
    input  logic [FB_AW-1:0]    waddr,
    input  logic [COLOUR_W-1:0] wdata,
    input  logic [FB_AW-1:0]    raddr,
    output logic [COLOUR_W-1:0] rdata
);

    logic [COLOUR_W-1:0] mem [0:FB_DEPTH-1];

    // Write and registered read share one clocked process so the read sees old data.
    always_ff @(posedge Clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_scanout.sv
// Pixel-plot sink and 640x480@60 VGA scan-out of a 160x120x3 framebuffer,
// each stored pixel replicated 4x4. The framebuffer is swept to BACKGROUND
// after every reset before plot writes are accepted.
module vga_scanout
    import vga_pkg::*;
#(
    parameter logic [2:0] BACKGROUND = 3'b000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] iX,
    input  logic [6:0] iY,
    input  logic [2:0] iColour,
    input  logic       iPlot,
    output logic       oReady,
    output logic [7:0] oVGA_R,
    output logic [7:0] oVGA_G,
    output logic [7:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N
);

    state_t state_q;
    state_t state_d;

    logic [FB_AW-1:0]    clr_addr;
    logic [9:0]          hcnt;
    logic [9:0]          vcnt;

    logic                we;
    logic [FB_AW-1:0]    waddr;
    logic [COLOUR_W-1:0] wdata;
    logic [FB_AW-1:0]    raddr;
    logic [COLOUR_W-1:0] rdata;

    logic                vis_c;
    logic                hs_n_c;
    logic                vs_n_c;
    logic                vis_q;
    logic                hs_n_q;
    logic                vs_n_q;

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear sweep address: steps once per cycle while clearing, parks at the last entry.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            clr_addr <= '0;
        end else if (state_q == S_CLEAR && clr_addr != FB_LAST) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Next state and framebuffer write mux (clear sweep vs. plot port).
    always_comb begin
        state_d = state_q;
        we      = 1'b0;
        waddr   = clr_addr;
        wdata   = BACKGROUND;
        unique case (state_q)
            S_CLEAR: begin
                we = Resetn;
                if (clr_addr == FB_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                waddr = fb_addr(iX, iY);
                wdata = iColour;
                we    = Resetn && iPlot && (iX < FB_W) && (iY < FB_H);
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    assign oReady = (state_q == S_RUN);

    // Free-running scan counters; they never stop, even while clearing.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Stage 0 decode: read address and raw visible/sync flags from the counters.
    always_comb begin
        raddr  = fb_addr(hcnt[9:2], vcnt[8:2]);
        vis_c  = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE);
        hs_n_c = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
        vs_n_c = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
    end

    fb_ram u_fb_ram (
        .Clock (Clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

    // Stage 1: delay the decode by one register to line up with the RAM read.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            vis_q  <= 1'b0;
            hs_n_q <= 1'b1;
            vs_n_q <= 1'b1;
        end else begin
            vis_q  <= vis_c;
            hs_n_q <= hs_n_c;
            vs_n_q <= vs_n_c;
        end
    end

    // Stage 2: output registers; colour expanded per channel and blanked outside the visible area.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_HS      <= 1'b1;
            oVGA_VS      <= 1'b1;
            oVGA_BLANK_N <= 1'b0;
        end else begin
            oVGA_R       <= {8{vis_q & rdata[2]}};
            oVGA_G       <= {8{vis_q & rdata[1]}};
            oVGA_B       <= {8{vis_q & rdata[0]}};
            oVGA_HS      <= hs_n_q;
            oVGA_VS      <= vs_n_q;
            oVGA_BLANK_N <= vis_q;
        end
    end

endmodule
